ascii_operand_parser: RTL and testbench
=======================================

Name: ascii_operand_parser

Overview:
- Front-end stage of the ASCII adder datapath. Consumes a serial stream of 8-bit ASCII characters, one per strobe, and parses them as "A+B=".
- Produces two packed-BCD operands for the downstream adder/complement logic, which consumes them over a valid/ready handshake.
- Flags malformed input and holds the error until it is explicitly cleared.

Parameters:
- DIGITS, 2, maximum number of decimal digits per operand (1..4).
- W, 4*DIGITS, derived operand width in bits (packed BCD, most significant digit in the top nibble). Not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- char_in  input  8  ASCII character; sampled only when char_valid=1.
- char_valid  input  1  one-cycle strobe qualifying char_in.
- op_a  output  W  operand A, packed BCD, right-aligned.
- op_b  output  W  operand B, packed BCD, right-aligned.
- op_valid  output  1  op_a/op_b hold a complete parsed pair.
- op_ready  input  1  downstream accepts the pair when op_valid && op_ready.
- err  output  1  parse error is latched.
- busy  output  1  1 when the state is not GET_A, or when the digit count is non-zero.

Behaviour:
- Reset (asynchronous, active-high): state=GET_A; op_a=0, op_b=0, digit count=0; op_valid=0, err=0, busy=0. Reset asserted mid-parse discards all partial data.
- States: GET_A, GET_B, DONE, ERROR. State changes occur only on a rising clk edge with char_valid=1, except DONE->GET_A, which is driven by the handshake.
- Digit classification: a character is a digit when 0x30 <= char <= 0x39; its nibble value is char-0x30 (char_in[3:0]).
- Digit accumulation in GET_A/GET_B: the target operand becomes {operand[W-5:0], nibble}; the digit count is incremented. The update is visible one cycle after the strobe.
- Overflow: a digit arriving while count==DIGITS -> ERROR. The operand is left unchanged.
- Spaces: 0x20 is ignored in GET_A and GET_B, with no state change.
- GET_A transitions:
  - '+' (0x2B) with count>=1 -> GET_B, count cleared.
  - '+' with count==0 -> ERROR.
  - Any other non-digit, non-space character -> ERROR.
- GET_B transitions:
  - '=' (0x3D) or CR (0x0D) with count>=1 -> DONE. op_valid rises in the next cycle, so latency is 1 clk from the terminator strobe.
  - Terminator with count==0 -> ERROR.
  - Any other non-digit, non-space character -> ERROR.
- DONE:
  - op_valid=1; op_a and op_b are held stable.
  - Every char_valid strobe is dropped, with no effect and no error.
  - When op_valid && op_ready on an edge: next cycle op_valid=0, op_a=0, op_b=0, count=0, state=GET_A.
  - A strobe coinciding with the accepting edge is dropped, not parsed.
- ERROR:
  - err=1; op_valid=0; operands are frozen at their last values.
  - Only ESC (0x1B) exits: next cycle err=0, operands and count cleared, state=GET_A. All other characters are ignored.
- ESC in GET_A or GET_B: abort. Operands and count are cleared, state stays/returns to GET_A, err stays 0.
- op_ready: ignored outside DONE.
- char_valid=0: holds all state; char_in is don't-care.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- DIGITS=2. After reset, stream "1","2","+","3","4","=" -> op_valid=1 exactly 1 clk after the '=' strobe; op_a=0x12, op_b=0x34. With op_ready held 0 for 5 clks, op_valid and the operands stay stable. Pulse op_ready -> next clk op_valid=0, op_a=op_b=0, busy=0.
- Stream "7"," ","+"," ","9",CR -> op_a=0x07, op_b=0x09, op_valid=1, err=0.
- Stream "1","2","3" -> err=1 after the third strobe; op_a stays 0x12. Then "5" -> err stays 1. Then ESC -> next clk err=0, op_a=0, busy=0. Then "4","+","4","=" -> op_a=0x04, op_b=0x04.
- Error cases, each from GET_A:
  - "+" first -> err=1.
  - "1","+","=" -> err=1.
  - "A" (0x41) -> err=1.
  - "/" (0x2F) and ":" (0x3A) -> err=1 (digit boundary check).
- While in DONE holding 0x12/0x34, send "9" on the same edge as op_ready=1 -> pair accepted, "9" dropped, op_a=0 afterwards. Then assert rst asynchronously mid-way through "5","+" -> outputs clear immediately without waiting for a clk edge.

Source files
------------

// File: rtl/ascii_operand_parser.sv
// ascii_operand_parser: parses a serial ASCII stream of the form "A+B=" into
// two right-aligned packed-BCD operands handed downstream over valid/ready.
// Malformed input latches an error that only ESC clears.
module ascii_operand_parser #(
  parameter int DIGITS = 2,
  localparam int W = 4 * DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   char_in,
  input  logic         char_valid,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  output logic         op_valid,
  input  logic         op_ready,
  output logic         err,
  output logic         busy
);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_EQ    = 8'h3D;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_ESC   = 8'h1B;

  // Three bits covers digit counts up to the largest legal DIGITS value (4).
  localparam logic [2:0] MAX_COUNT = 3'(DIGITS);

  typedef enum logic [1:0] {
    GET_A,
    GET_B,
    DONE,
    ERROR
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [2:0]     count;
  logic [2:0]     count_n;
  logic [W-1:0]   a_n;
  logic [W-1:0]   b_n;
  logic           is_digit;
  logic [3:0]     nibble;

  assign is_digit = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign nibble   = char_in[3:0];

  // Next-state and next-operand decode; every path defaults to holding state.
  always_comb begin
    state_n = state;
    count_n = count;
    a_n     = op_a;
    b_n     = op_b;
    case (state)
      GET_A, GET_B: begin
        if (char_valid) begin
          if (is_digit) begin
            if (count == MAX_COUNT) begin
              state_n = ERROR;
            end else begin
              if (state == GET_A) begin
                a_n = (op_a << 4) | W'(nibble);
              end else begin
                b_n = (op_b << 4) | W'(nibble);
              end
              count_n = count + 3'd1;
            end
          end else if (char_in == CH_SPACE) begin
            state_n = state;
          end else if (char_in == CH_ESC) begin
            state_n = GET_A;
            count_n = '0;
            a_n     = '0;
            b_n     = '0;
          end else if ((state == GET_A) && (char_in == CH_PLUS)) begin
            if (count != '0) begin
              state_n = GET_B;
              count_n = '0;
            end else begin
              state_n = ERROR;
            end
          end else if ((state == GET_B) && ((char_in == CH_EQ) || (char_in == CH_CR))) begin
            if (count != '0) begin
              state_n = DONE;
            end else begin
              state_n = ERROR;
            end
          end else begin
            state_n = ERROR;
          end
        end
      end
      DONE: begin
        // Strobes are dropped here; only the downstream handshake leaves DONE.
        if (op_ready) begin
          state_n = GET_A;
          count_n = '0;
          a_n     = '0;
          b_n     = '0;
        end
      end
      ERROR: begin
        if (char_valid && (char_in == CH_ESC)) begin
          state_n = GET_A;
          count_n = '0;
          a_n     = '0;
          b_n     = '0;
        end
      end
      default: begin
        state_n = GET_A;
        count_n = '0;
        a_n     = '0;
        b_n     = '0;
      end
    endcase
  end

  // State, operands and all status outputs are registered from the decoded next values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GET_A;
      count    <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      op_a     <= a_n;
      op_b     <= b_n;
      op_valid <= (state_n == DONE);
      err      <= (state_n == ERROR);
      busy     <= (state_n != GET_A) || (count_n != '0);
    end
  end

endmodule

// File: tb/tb_ascii_operand_parser.sv
// tb_ascii_operand_parser: directed stimulus with a scoreboard; each parsed
// pair or latched error is queued as expected and checked by a monitor.
module tb_ascii_operand_parser;

  localparam int DIGITS = 2;
  localparam int W = 4 * DIGITS;

  logic         clk;
  logic         rst;
  logic [7:0]   char_in;
  logic         char_valid;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_valid;
  logic         op_ready;
  logic         err;
  logic         busy;

  typedef struct {
    bit           is_err;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  ascii_operand_parser #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .op_a       (op_a),
    .op_b       (op_b),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .err        (err),
    .busy       (busy)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
  endtask

  // Present one character for exactly one sampling edge, then release.
  task automatic applyStimulus(input logic [7:0] c);
    char_in    = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic acceptPair();
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    op_ready = 1'b0;
  endtask

  task automatic expectPair(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.is_err = 1'b0; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic expectErr(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.is_err = 1'b1; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  // Monitor: every new pair or newly latched error is matched against the queue head.
  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;
  always @(negedge clk) begin
    if ((op_valid && !prev_valid) || (err && !prev_err)) begin
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_event: actual valid=%0b err=%0b a=0x%0h b=0x%0h required=none",
                 op_valid, err, op_a, op_b);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ((err === e.is_err) && (op_valid === !e.is_err) && (op_a === e.a) && (op_b === e.b))
          passed++;
        else
          $display("[TB] FAIL sb_event: actual err=%0b valid=%0b a=0x%0h b=0x%0h required err=%0b a=0x%0h b=0x%0h",
                   err, op_valid, op_a, op_b, e.is_err, e.a, e.b);
      end
    end
    prev_valid = op_valid;
    prev_err   = err;
  end

  initial begin
    rst        = 1'b1;
    char_in    = 8'h00;
    char_valid = 1'b0;
    op_ready   = 1'b0;
    #12;
    checkOutput("reset_op_a", 32'(op_a), 32'h0);
    checkOutput("reset_op_b", 32'(op_b), 32'h0);
    checkOutput("reset_flags", {29'b0, op_valid, err, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // "12+34=" then hold with op_ready low, then accept.
    expectPair(8'h12, 8'h34);
    applyStimulus("1"); applyStimulus("2"); applyStimulus("+");
    applyStimulus("3"); applyStimulus("4");
    checkOutput("pre_term_valid", 32'(op_valid), 32'h0);
    checkOutput("mid_busy", 32'(busy), 32'h1);
    applyStimulus("=");
    checkOutput("latency_valid", 32'(op_valid), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 32'(op_valid), 32'h1);
      checkOutput("hold_ops", {16'b0, op_a, op_b}, 32'h1234);
    end
    acceptPair();
    checkOutput("accept_valid", 32'(op_valid), 32'h0);
    checkOutput("accept_ops", {16'b0, op_a, op_b}, 32'h0);
    checkOutput("accept_busy", 32'(busy), 32'h0);

    // Spaces ignored, CR terminator.
    expectPair(8'h07, 8'h09);
    applyStimulus("7"); applyStimulus(" "); applyStimulus("+");
    applyStimulus(" "); applyStimulus("9"); applyStimulus(8'h0D);
    checkOutput("cr_err", 32'(err), 32'h0);
    checkOutput("cr_ops", {16'b0, op_a, op_b}, 32'h0709);
    acceptPair();

    // Overflow on third digit, error holds, ESC recovers.
    expectErr(8'h12, 8'h00);
    applyStimulus("1"); applyStimulus("2"); applyStimulus("3");
    checkOutput("ovf_err", 32'(err), 32'h1);
    checkOutput("ovf_op_a", 32'(op_a), 32'h12);
    applyStimulus("5");
    checkOutput("err_sticky", 32'(err), 32'h1);
    checkOutput("err_frozen_a", 32'(op_a), 32'h12);
    applyStimulus(8'h1B);
    checkOutput("esc_err", 32'(err), 32'h0);
    checkOutput("esc_op_a", 32'(op_a), 32'h0);
    checkOutput("esc_busy", 32'(busy), 32'h0);
    expectPair(8'h04, 8'h04);
    applyStimulus("4"); applyStimulus("+"); applyStimulus("4"); applyStimulus("=");
    acceptPair();

    // Error cases from GET_A, each cleared with ESC.
    expectErr(8'h00, 8'h00);
    applyStimulus("+");
    checkOutput("plus_first_err", 32'(err), 32'h1);
    applyStimulus(8'h1B);
    expectErr(8'h01, 8'h00);
    applyStimulus("1"); applyStimulus("+"); applyStimulus("=");
    checkOutput("empty_b_err", 32'(err), 32'h1);
    applyStimulus(8'h1B);
    expectErr(8'h00, 8'h00);
    applyStimulus("A");
    checkOutput("alpha_err", 32'(err), 32'h1);
    applyStimulus(8'h1B);
    expectErr(8'h00, 8'h00);
    applyStimulus("/");
    checkOutput("slash_err", 32'(err), 32'h1);
    applyStimulus(8'h1B);
    expectErr(8'h00, 8'h00);
    applyStimulus(":");
    checkOutput("colon_err", 32'(err), 32'h1);
    applyStimulus(8'h1B);
    checkOutput("post_esc_err", 32'(err), 32'h0);

    // Strobe coinciding with the accepting edge is dropped.
    expectPair(8'h12, 8'h34);
    applyStimulus("1"); applyStimulus("2"); applyStimulus("+");
    applyStimulus("3"); applyStimulus("4"); applyStimulus("=");
    char_in = "9"; char_valid = 1'b1; op_ready = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0; op_ready = 1'b0;
    checkOutput("drop_valid", 32'(op_valid), 32'h0);
    checkOutput("drop_op_a", 32'(op_a), 32'h0);
    checkOutput("drop_busy", 32'(busy), 32'h0);

    // Asynchronous reset in the middle of "5","+".
    applyStimulus("5");
    checkOutput("pre_rst_op_a", 32'(op_a), 32'h05);
    checkOutput("pre_rst_busy", 32'(busy), 32'h1);
    char_in = "+"; char_valid = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_op_a", 32'(op_a), 32'h0);
    checkOutput("async_rst_flags", {29'b0, op_valid, err, busy}, 32'h0);
    char_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    expectErr(8'h00, 8'h00);
    applyStimulus("+");
    checkOutput("post_rst_plus_err", 32'(err), 32'h1);
    applyStimulus(8'h1B);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("sb_drain", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
